// File: rtl/pingpong_vu_meter.sv
// Purpose: ping-pong sample buffer feeding a peak-envelope VU meter with a 6-LED bar.
// Latency: a buffer is readable the clock after its last write; LEDs lag by up to LED_DIV clocks.
// Backpressure: none; writes are never stalled, and a buffer completing mid-read restarts the read.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset
//   sample_i       signed audio sample, written when sample_ready_i is high
//   sample_ready_i one-cycle write strobe
//   buffer_ready_o one-cycle pulse when a bank fills and the banks swap
//   read_enable_o  high while the read bank still holds unread samples
//   read_data_o    read-bank sample at the current read address
//   read_ack_o     meter consume strobe, one sample per clock
//   leds_o         thermometer-coded level, refreshed every LED_DIV clocks
module pingpong_vu_meter #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 256,
  parameter int DECAY_SHIFT = 11,
  parameter int SCALE_SHIFT = 2,
  parameter int LED_DIV     = 1000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] sample_i,
  input  logic             sample_ready_i,
  output logic             buffer_ready_o,
  output logic             read_enable_o,
  output logic [WIDTH-1:0] read_data_o,
  output logic             read_ack_o,
  output logic [5:0]       leds_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;
  localparam int XW = WIDTH + SCALE_SHIFT;

  localparam logic [WIDTH-1:0] MAG_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, READ} state_t;

  // Both banks live in one array; the top index bit is the bank number.
  logic [WIDTH-1:0] mem [2*DEPTH];

  logic             wr_bank;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic             buf_done;
  state_t           state, state_nxt;

  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] env;
  logic [WIDTH-1:0] env_step;
  logic [XW-1:0]    env_scaled;
  logic [WIDTH-1:0] disp;
  logic [5:0]       leds_nxt;
  logic [DW-1:0]    div_cnt;

  // ---------------------------------------------------------------- storage
  assign buf_done = sample_ready_i && (wr_addr == AW'(DEPTH-1));

  always_ff @(posedge clk_i) begin
    if (sample_ready_i) mem[{wr_bank, wr_addr}] <= sample_i;
  end

  // The read bank is always the one not being written.
  assign read_data_o = read_enable_o ? mem[{~wr_bank, rd_addr}] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_bank        <= 1'b0;
      wr_addr        <= '0;
      rd_addr        <= '0;
      read_enable_o  <= 1'b0;
      buffer_ready_o <= 1'b0;
    end else begin
      buffer_ready_o <= buf_done;
      if (sample_ready_i) wr_addr <= buf_done ? '0 : wr_addr + AW'(1);
      // A completing buffer wins over a pending ack: the reader restarts
      // at the top of the freshly filled bank (overrun).
      if (buf_done) begin
        wr_bank       <= ~wr_bank;
        rd_addr       <= '0;
        read_enable_o <= 1'b1;
      end else if (read_ack_o) begin
        rd_addr <= rd_addr + AW'(1);
        if (rd_addr == AW'(DEPTH-1)) read_enable_o <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------ meter FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    read_ack_o = 1'b0;
    case (state)
      IDLE: if (buffer_ready_o) state_nxt = READ;
      READ: begin
        read_ack_o = read_enable_o;
        if (!read_enable_o) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------------- envelope
  // The most negative sample has no positive twin; clamp it to full scale.
  always_comb begin
    if (!sample_i[WIDTH-1])      mag = sample_i;
    else if (sample_i == MOST_NEG) mag = MAG_MAX;
    else                           mag = -sample_i;
  end

  // Proportional decay with a floor of one LSB so small levels still reach zero.
  assign env_step = ((env >> DECAY_SHIFT) != '0) ? (env >> DECAY_SHIFT) : WIDTH'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      env <= '0;
    end else if (sample_ready_i) begin
      if (mag > env) env <= mag;
    end else if (env != '0) begin
      env <= env - env_step;
    end
  end

  // -------------------------------------------------------------- display
  assign env_scaled = XW'(env) << SCALE_SHIFT;
  assign disp       = ((env_scaled >> WIDTH) != '0) ? '1 : env_scaled[WIDTH-1:0];

  // Thresholds are octave-spaced, topping out at half of full scale.
  always_comb begin
    leds_nxt = '0;
    for (int k = 0; k < 6; k++) begin
      leds_nxt[k] = (disp >= (WIDTH'(1) << (WIDTH - 6 + k)));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt <= '0;
      leds_o  <= '0;
    end else if (div_cnt == DW'(LED_DIV-1)) begin
      div_cnt <= '0;
      leds_o  <= leds_nxt;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: tb/tb_pingpong_vu_meter.sv
// Purpose: directed self-checking bench for pingpong_vu_meter.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: none; the bench acts as both sample source and observer of the meter's reads.
module tb_pingpong_vu_meter;

  localparam int LD = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sample = '0;
  logic        sample_ready = 1'b0;
  logic        buffer_ready_o;
  logic        read_enable_o;
  logic [15:0] read_data_o;
  logic        read_ack_o;
  logic [5:0]  leds_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int first_ack = 0;
  int last_ack = 0;
  int br_cnt = 0;
  int steps = 0;
  logic [5:0]  prev_leds;
  logic [15:0] exp_q[$];

  pingpong_vu_meter #(
    .WIDTH(16), .DEPTH(256), .DECAY_SHIFT(11), .SCALE_SHIFT(2), .LED_DIV(LD)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .sample_i(sample),
    .sample_ready_i(sample_ready),
    .buffer_ready_o(buffer_ready_o),
    .read_enable_o(read_enable_o),
    .read_data_o(read_data_o),
    .read_ack_o(read_ack_o),
    .leds_o(leds_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, observe on the falling edge, advance past the rising edge.
  task automatic tick(input logic wr, input logic [15:0] d);
    logic [15:0] e;
    sample_ready = wr;
    sample       = d;
    @(negedge clk);
    if (buffer_ready_o) br_cnt++;
    if (read_ack_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_ack: observed data 0x%0h expected no ack", read_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("read_data", 32'(read_data_o), 32'(e));
      end
      if (ack_cnt == 0) first_ack = cyc;
      last_ack = cyc;
      ack_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
    sample_ready = 1'b0;
  endtask

  task automatic clr_stats();
    ack_cnt = 0;
    br_cnt  = 0;
  endtask

  task automatic drain(input int n, input int led_at, input logic [5:0] led_exp, input string tag);
    for (int k = 0; k < n; k++) begin
      tick(1'b0, 16'h0000);
      if (k == led_at) chk({tag, "_leds"}, 32'(leds_o), 32'(led_exp));
    end
  endtask

  task automatic end_check(input string tag, input int exp_acks, input int exp_br);
    chk({tag, "_ack_count"}, ack_cnt, exp_acks);
    chk({tag, "_acks_consecutive"}, last_ack - first_ack + 1, ack_cnt);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    chk({tag, "_ready_pulses"}, br_cnt, exp_br);
    chk({tag, "_enable_low"}, 32'(read_enable_o), 32'd0);
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_buffer_ready"}, 32'(buffer_ready_o), 32'd0);
    chk({tag, "_read_enable"},  32'(read_enable_o),  32'd0);
    chk({tag, "_read_ack"},     32'(read_ack_o),     32'd0);
    chk({tag, "_leds"},         32'(leds_o),         32'd0);
  endtask

  initial begin
    // ---- reset state
    #2 rst = 1'b1;
    #1;
    reset_outputs_zero("rst0");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ---- first buffer 0x1000..0x10FF
    clr_stats();
    for (int i = 0; i < 256; i++) exp_q.push_back(16'h1000 + 16'(i));
    for (int i = 0; i < 255; i++) tick(1'b1, 16'h1000 + 16'(i));
    chk("s1_no_early_ready", br_cnt, 0);
    chk("s1_no_early_enable", 32'(read_enable_o), 32'd0);
    tick(1'b1, 16'h10FF);
    chk("s1_ready_pulse", 32'(buffer_ready_o), 32'd1);
    chk("s1_enable", 32'(read_enable_o), 32'd1);
    chk("s1_no_ack_yet", 32'(read_ack_o), 32'd0);
    chk("s1_first_data", 32'(read_data_o), 32'h1000);
    drain(260, 70, 6'b011111, "s1");
    end_check("s1", 256, 1);
    repeat (20) tick(1'b0, 16'h0000);
    chk("s1_enable_stays_low", 32'(read_enable_o), 32'd0);

    // ---- second buffer 0x2000..0x20FF
    clr_stats();
    for (int i = 0; i < 256; i++) exp_q.push_back(16'h2000 + 16'(i));
    for (int i = 0; i < 256; i++) tick(1'b1, 16'h2000 + 16'(i));
    chk("s2_ready_pulse", 32'(buffer_ready_o), 32'd1);
    drain(260, 30, 6'b111111, "s2");
    end_check("s2", 256, 1);
    repeat (20) tick(1'b0, 16'h0000);

    // ---- most negative sample, then decay to silence
    clr_stats();
    tick(1'b1, 16'h8000);
    repeat (LD + 2) tick(1'b0, 16'h0000);
    chk("s3_full_scale", 32'(leds_o), 32'h3F);
    prev_leds = leds_o;
    steps = 0;
    for (int n = 0; n < 20000; n++) begin
      tick(1'b0, 16'h0000);
      if (leds_o !== prev_leds) begin
        steps++;
        chk("s3_decay_step", 32'(leds_o), 32'(prev_leds >> 1));
        prev_leds = leds_o;
      end
    end
    chk("s3_leds_off", 32'(leds_o), 32'd0);
    chk("s3_step_count", steps, 6);
    chk("s3_no_reads", ack_cnt, 0);

    // ---- reset at ack #100; bank holds 0x8000 then 0x3000.. (write address was 1)
    clr_stats();
    exp_q.push_back(16'h8000);
    for (int i = 0; i < 99; i++) exp_q.push_back(16'h3000 + 16'(i));
    for (int i = 0; i < 255; i++) tick(1'b1, 16'h3000 + 16'(i));
    chk("s4_ready_pulse", 32'(buffer_ready_o), 32'd1);
    for (int n = 0; n < 300 && ack_cnt < 100; n++) tick(1'b0, 16'h0000);
    chk("s4_acks_before_reset", ack_cnt, 100);
    chk("s4_mid_read", 32'(read_ack_o), 32'd1);
    rst = 1'b1;
    #1;
    reset_outputs_zero("s4_rst");
    chk("s4_queue_left", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("s4_enable_after_rst", 32'(read_enable_o), 32'd0);

    // partial fill discarded by a reset pulse with no clock edge
    for (int i = 0; i < 100; i++) tick(1'b1, 16'h7000 + 16'(i));
    rst = 1'b1;
    #2 rst = 1'b0;
    clr_stats();
    for (int i = 0; i < 256; i++) exp_q.push_back(16'h4000 + 16'(i));
    for (int i = 0; i < 255; i++) tick(1'b1, 16'h4000 + 16'(i));
    chk("s4_no_early_ready", br_cnt, 0);
    chk("s4_no_early_enable", 32'(read_enable_o), 32'd0);
    tick(1'b1, 16'h40FF);
    chk("s4_new_ready", 32'(buffer_ready_o), 32'd1);
    drain(260, -1, 6'b000000, "s4");
    end_check("s4", 256, 1);

    // ---- overrun: second buffer completes while the first is being read
    clr_stats();
    for (int i = 0; i < 255; i++) exp_q.push_back(16'h5000 + 16'(i));
    for (int i = 0; i < 256; i++) exp_q.push_back(16'h6000 + 16'(i));
    for (int i = 0; i < 512; i++)
      tick(1'b1, (i < 256) ? 16'h5000 + 16'(i) : 16'h6000 + 16'(i - 256));
    drain(260, -1, 6'b000000, "s5");
    end_check("s5", 511, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
